// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - receive-side BIST checker for the x^4+x^3+1 Fibonacci LFSR pattern stream
// Self-synchronises on the incoming words, flywheels once locked, and counts locked-state mismatches.
module lfsr_checker #(
  parameter int NBIT     = 4,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NBIT:1]    din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_e           state_q, state_d;
  logic [NBIT:1]    pred_q, pred_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [3:0]       mcnt_inc, bcnt_inc;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             cnt_inc;
  logic             din_match;

  function automatic logic [NBIT:1] lfsr_next(input logic [NBIT:1] x);
    return {x[NBIT-1:1], x[NBIT] ^ x[NBIT-1]};
  endfunction

  assign mcnt_inc  = mcnt_q + 4'd1;
  assign bcnt_inc  = bcnt_q + 4'd1;
  assign din_match = (din == pred_q);

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    mcnt_d  = mcnt_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      unique case (state_q)
        SEEK: begin
          // All-zero is the LFSR lock-up word and can never seed a valid run.
          if (din != '0) begin
            pred_d  = lfsr_next(din);
            mcnt_d  = 4'd0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          pred_d = lfsr_next(din);
          if (din_match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LOCK_N) begin
              state_d = LOCK;
              bcnt_d  = 4'd0;
            end
          end else begin
            mcnt_d = 4'd0;
            if (din == '0) state_d = SEEK;
          end
        end
        LOCK: begin
          // Flywheel: prediction advances from itself so bad words cannot corrupt it.
          pred_d = lfsr_next(pred_q);
          if (din_match) begin
            bcnt_d = 4'd0;
          end else begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            bcnt_d  = bcnt_inc;
            if (bcnt_inc == LOSS_N) state_d = SEEK;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (cnt_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  assign locked_d = (state_d == LOCK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SEEK;
      pred_q    <= '0;
      mcnt_q    <= 4'd0;
      bcnt_q    <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      mcnt_q    <= mcnt_d;
      bcnt_q    <= bcnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:1] din;
  logic       clr_cnt;
  logic       locked, err;
  logic [7:0] err_cnt;
  logic       locked_s, err_s;
  logic [1:0] err_cnt_s;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [4:1] seq [0:14] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001,
                             4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                             4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  lfsr_checker #(.ERR_W(2), .LOSS_CNT(15)) u_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s)
  );

  task automatic step(input logic e, input logic [4:1] d);
    @(negedge clk);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_lock();
    rst = 1'b0;
    step(1'b0, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, seq[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(1'b1, 4'b1111);
    rst = 1'b1;
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_lock();
    int errs = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq[i]);
      n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early_%0d: locked=%b want 0", i, locked); end
    end
    step(1'b1, seq[3]);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_4: locked=%b want 1", locked); end
    for (int i = 4; i < 8; i++) begin
      step(1'b1, seq[i]);
      if (err !== 1'b0) errs++;
    end
    n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL lock_no_err: err cycles=%0d want 0", errs); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: locked=%b want 1", locked); end
  endtask

  task automatic test_single_error();
    do_lock();
    step(1'b1, 4'b0000);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL single_err_pulse: err=%b want 1", err); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: locked=%b want 1", locked); end
    step(1'b1, 4'b0010);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_flywheel: err=%b want 0", err); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL single_cnt_hold: got %0d want 1", err_cnt); end
  endtask

  task automatic test_loss();
    do_lock();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0000);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL loss_err_%0d: err=%b want 1", i, err); end
      n_cmp++; if (locked !== (i < 3)) begin n_fail++; $display("FAIL loss_locked_%0d: locked=%b want %b", i, locked, i < 3); end
    end
    n_cmp++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL loss_err_cnt: got %0d want 4", err_cnt); end
    for (int i = 8; i < 11; i++) step(1'b1, seq[i]);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: locked=%b want 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL relock_err: err=%b want 0", err); end
    step(1'b1, seq[11]);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: locked=%b want 1", locked); end
    n_cmp++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL relock_cnt: got %0d want 4", err_cnt); end
  endtask

  task automatic test_resync();
    rst = 1'b0;
    step(1'b0, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL seek_zero: locked=%b want 0", locked); end
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b0101);
    step(1'b1, 4'b1011);
    step(1'b1, 4'b0111);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL resync_early: locked=%b want 0", locked); end
    step(1'b1, 4'b1111);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL resync_lock: locked=%b want 1", locked); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL resync_no_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_saturation();
    do_lock();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0000);
      if (i == 2) begin
        n_cmp++; if (err_cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_reach: got %0d want 3", err_cnt_s); end
      end
    end
    n_cmp++; if (err_cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_stick: got %0d want 3", err_cnt_s); end
    n_cmp++; if (locked_s !== 1'b1) begin n_fail++; $display("FAIL sat_locked: locked=%b want 1", locked_s); end
    clr_cnt = 1'b1;
    step(1'b1, 4'b0000);
    clr_cnt = 1'b0;
    n_cmp++; if (err_cnt_s !== 2'd0) begin n_fail++; $display("FAIL sat_clr_wins: got %0d want 0", err_cnt_s); end
    n_cmp++; if (err_s !== 1'b1) begin n_fail++; $display("FAIL sat_clr_err: err=%b want 1", err_s); end
    n_cmp++; if (locked_s !== 1'b1) begin n_fail++; $display("FAIL sat_clr_locked: locked=%b want 1", locked_s); end
  endtask

  task automatic test_gap_and_reset();
    rst = 1'b0;
    step(1'b0, 4'b0000);
    rst = 1'b1;
    step(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0101);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_unlocked: locked=%b want 0", locked); end
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b1000);
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_lock: locked=%b want 1", locked); end
    step(1'b0, 4'b0000);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL gap_idle_err: err=%b want 0", err); end
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL gap_err_one_cycle: err=%b want 0", err); end
    step(1'b1, 4'b0000);
    n_cmp++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL gap_err_cnt: got %0d want 2", err_cnt); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gap_still_locked: locked=%b want 1", locked); end
    rst = 1'b0;
    clr_cnt = 1'b0;
    step(1'b1, 4'b0000);
    rst = 1'b1;
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: locked=%b want 0", locked); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: err=%b want 0", err); end
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    din     = 4'b0000;
    clr_cnt = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_resync();
    test_saturation();
    test_gap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side BIST checker for the 4-bit Fibonacci LFSR pattern stream (polynomial x^4+x^3+1, next state = {s[3:1], s[4]^s[3]}, period 15). Takes one parallel 4-bit pattern word per enabled cycle, self-synchronises to the incoming sequence, flywheels on its own prediction once locked, and reports per-word errors plus a saturating error count. Sits at the far end of the test path, opposite the pattern generator, and needs no seed input.

## Interface
- NBIT, 4: pattern word width; taps fixed at bits 4 and 3; only 4 supported.
- LOCK_CNT, 3: consecutive correct predictions required to declare lock (1..15).
- LOSS_CNT, 4: consecutive mismatches while locked that drop lock (1..15).
- ERR_W, 8: width of the error counter.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  one clock; reset is synchronous and active-low (rst==0 at a clk edge resets).
- en  in  1  din valid this cycle; when 0, all state holds and err is 0.
- din  in  [4:1]  received pattern word.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  checker is in LOCK state.
- err  out  1  one-cycle pulse: last enabled word mismatched while locked.
- err_cnt  out  [ERR_W-1:0]  count of locked-state mismatches, saturating at all-ones.

## Operation
- Internal: pred[4:1] (expected next word), mcnt (match count), bcnt (consecutive-bad count), state in {SEEK, SYNC, LOCK}. next(x) = {x[3:1], x[4]^x[3]}.
- SEEK: on en, din!=0 -> pred<=next(din), mcnt<=0, go SYNC. din==0 (lock-up word) -> stay SEEK.
- SYNC: on en, din==pred -> pred<=next(din), mcnt++; when incremented value reaches LOCK_CNT go LOCK, bcnt<=0. din!=pred -> reseed: pred<=next(din), mcnt<=0, stay SYNC; if din==0 go SEEK instead. No errors counted in SEEK/SYNC.
- LOCK: on en, pred<=next(pred) always (flywheel, never reseeded from din). din==pred -> bcnt<=0. din!=pred -> err pulse, err_cnt increment (saturating), bcnt++; when incremented bcnt reaches LOSS_CNT go SEEK, locked drops.
- err_cnt: clears only on reset or clr_cnt; clr_cnt and an increment in the same cycle -> clr wins, err_cnt=0. clr_cnt does not affect state, pred, locked.
- en=0: pred, counters, state, err_cnt hold (clr_cnt still acts); err=0.
- Reset values: state SEEK, pred 0000, mcnt 0, bcnt 0, locked 0, err 0, err_cnt 0. Reset mid-operation (any state) returns to these values on that edge; reset overrides en and clr_cnt.

## Timing
- All outputs registered; no combinational path din->outputs.
- Lock latency: first nonzero word at edge N enters SYNC; locked=1 after edge N+LOCK_CNT if all following enabled words match (default: after the 4th enabled word).
- err asserted for exactly the cycle following the edge that sampled the bad word; err_cnt updated at that same edge.
- Loss: locked=0 after the edge sampling the LOSS_CNT-th consecutive bad word; that word is counted and pulses err.
- Idle cycles (en=0) between words do not break a run of matches or mismatches.
- Wrap-around: sequence period 15 is tracked naturally; 1111 following 0111 is a match.

## Test plan
- Lock: rst low 1 cycle, then en=1, din = 1111,1110,1100,1000 -> locked=1 after 4th edge, err never set, err_cnt=0; continue 0001,0010,0100,1001 -> no errors.
- Single error: locked, send 0000 in place of 0001, then 0010 -> err pulse 1 cycle, err_cnt=1, locked stays 1, 0010 accepted (flywheel).
- Loss of lock: locked, send 4 consecutive wrong words -> err high 4 cycles, err_cnt=4, locked=0 after 4th; then correct sequence from 0011 relocks after 4 words.
- Lock-up word / resync: in SEEK feed 0000 x5 -> stays SEEK, locked=0; in SYNC after 1111,1110 send 0101 -> reseed, mcnt=0, needs 0101,1011,0111,1111 before lock.
- Saturation/clear with ERR_W=2: 5 locked errors (LOSS_CNT=15) -> err_cnt sticks at 3; clr_cnt together with 6th error -> err_cnt=0.
- en gaps and reset: 1111,en=0 x3,1110,1100,1000 -> locks; assert rst while locked with err_cnt=2 -> next cycle locked=0, err_cnt=0, err=0.
